// File: rtl/simple_pkg.sv
// Shared encodings for the simple ISA: branch opcode fields, condition codes,
// ALU flag bit positions and the branch_resolve state enum.
package simple_pkg;

  localparam logic [1:0] BR_OP     = 2'b10;
  localparam logic [2:0] BR_UNCOND = 3'b100;
  localparam logic [2:0] BR_COND   = 3'b111;

  localparam logic [2:0] CC_BE  = 3'b000;
  localparam logic [2:0] CC_BLT = 3'b001;
  localparam logic [2:0] CC_BLE = 3'b010;
  localparam logic [2:0] CC_BNE = 3'b011;

  // Flags arrive as {S,Z,C,V}
  localparam int FLAG_S = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_FLAGS,
    ST_REDIRECT,
    ST_FLUSH
  } br_state_t;

  function automatic logic is_uncond_branch(input logic [15:0] op);
    return (op[15:14] == BR_OP) && (op[13:11] == BR_UNCOND) && (op[10:8] == 3'b000);
  endfunction

  function automatic logic is_cond_branch(input logic [15:0] op);
    return (op[15:14] == BR_OP) && (op[13:11] == BR_COND) &&
           ((op[10:8] == CC_BE) || (op[10:8] == CC_BLT) ||
            (op[10:8] == CC_BLE) || (op[10:8] == CC_BNE));
  endfunction

endpackage

// File: rtl/branch_cond.sv
// Combinational branch condition evaluator: condition code plus {S,Z,C,V}
// flags in, taken out. Unknown codes are never taken.
module branch_cond
  import simple_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [3:0] flags,
  output logic       taken
);

  logic lt;

  always_comb begin
    lt    = flags[FLAG_S] ^ flags[FLAG_V];
    taken = 1'b0;
    case (cond)
      CC_BE:   taken = flags[FLAG_Z];
      CC_BLT:  taken = lt;
      CC_BLE:  taken = flags[FLAG_Z] | lt;
      CC_BNE:  taken = ~flags[FLAG_Z];
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// Branch resolution on the fetch feedback path: decodes branches, waits for
// flags, redirects fetch and squashes wrong-path beats. BRANCH_STATS_EN adds counters.
module branch_resolve
  import simple_pkg::*;
#(
  parameter int unsigned FLUSH_DEPTH = 2,
  parameter int unsigned STAT_WIDTH  = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [15:0] operation,
  input  logic [15:0] pcin,
  input  logic        flags_valid,
  input  logic [3:0]  flags,
  input  logic        pc_ack,
  output logic        pcsrcout,
  output logic [15:0] pctargetout,
  output logic        stall,
  output logic        kill
`ifdef BRANCH_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0] branch_count,
  output logic [STAT_WIDTH-1:0] taken_count
`endif
);

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_DEPTH);

  br_state_t   state;
  logic [2:0]  cond_q;
  logic [2:0]  flush_cnt;
  logic [15:0] last_pc;

  logic        accept_b;
  logic        accept_c;
  logic        resolve_now;
  logic        taken;
  logic        redirect_evt;
  logic [2:0]  cond_sel;
  logic [15:0] disp_ext;

  // While waiting for flags the condition comes from the latched copy, since
  // upstream may present unrelated words on operation.
  always_comb begin
    accept_b     = instr_valid && (state == ST_IDLE) && is_uncond_branch(operation);
    accept_c     = instr_valid && (state == ST_IDLE) && is_cond_branch(operation);
    cond_sel     = (state == ST_WAIT_FLAGS) ? cond_q : operation[10:8];
    resolve_now  = flags_valid && (accept_c || (state == ST_WAIT_FLAGS));
    redirect_evt = accept_b || (resolve_now && taken);
    disp_ext     = {{8{operation[7]}}, operation[7:0]};
  end

  branch_cond u_cond (
    .cond  (cond_sel),
    .flags (flags),
    .taken (taken)
  );

  assign kill = (state == ST_FLUSH) && instr_valid;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      pcsrcout    <= 1'b0;
      pctargetout <= 16'h0000;
      stall       <= 1'b0;
      cond_q      <= 3'b000;
      flush_cnt   <= 3'd0;
      last_pc     <= 16'h0000;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept_b || accept_c) begin
            pctargetout <= disp_ext;
            cond_q      <= operation[10:8];
            last_pc     <= pcin;
          end
          if (redirect_evt) begin
            state    <= ST_REDIRECT;
            pcsrcout <= 1'b1;
            stall    <= 1'b1;
          end else if (accept_c && !flags_valid) begin
            state <= ST_WAIT_FLAGS;
            stall <= 1'b1;
          end
        end
        ST_WAIT_FLAGS: begin
          if (flags_valid) begin
            if (taken) begin
              state    <= ST_REDIRECT;
              pcsrcout <= 1'b1;
            end else begin
              state <= ST_IDLE;
              stall <= 1'b0;
            end
          end
        end
        ST_REDIRECT: begin
          if (pc_ack) begin
            pcsrcout  <= 1'b0;
            stall     <= 1'b0;
            flush_cnt <= FLUSH_INIT;
            state     <= (FLUSH_DEPTH == 0) ? ST_IDLE : ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          // A zero count is treated like the last beat so FLUSH can never stick.
          if (instr_valid) begin
            if (flush_cnt <= 3'd1) begin
              flush_cnt <= 3'd0;
              state     <= ST_IDLE;
            end else begin
              flush_cnt <= flush_cnt - 3'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  logic eval_evt;

  assign eval_evt = accept_b || resolve_now;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      branch_count <= '0;
      taken_count  <= '0;
    end else begin
      if (eval_evt && (branch_count != {STAT_WIDTH{1'b1}}))
        branch_count <= branch_count + 1'b1;
      if (redirect_evt && (taken_count != {STAT_WIDTH{1'b1}}))
        taken_count <= taken_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed scenarios plus randomized
// branch streams against a transaction-level model. Define BRANCH_STATS_EN for counters.
module tb_branch_resolve;

  localparam int FD = 2;
  localparam int SW = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic [15:0] operation;
  logic [15:0] pcin;
  logic        flags_valid;
  logic [3:0]  flags;
  logic        pc_ack;
  logic        pcsrcout;
  logic [15:0] pctargetout;
  logic        stall;
  logic        kill;
`ifdef BRANCH_STATS_EN
  logic [SW-1:0] branch_count;
  logic [SW-1:0] taken_count;
`endif

  int checks = 0;
  int passes = 0;
  int exp_branches = 0;
  int exp_taken = 0;

  always #5 clock = ~clock;

  branch_resolve #(.FLUSH_DEPTH(FD), .STAT_WIDTH(SW)) dut (
    .clock       (clock),
    .reset       (reset),
    .instr_valid (instr_valid),
    .operation   (operation),
    .pcin        (pcin),
    .flags_valid (flags_valid),
    .flags       (flags),
    .pc_ack      (pc_ack),
    .pcsrcout    (pcsrcout),
    .pctargetout (pctargetout),
    .stall       (stall),
    .kill        (kill)
`ifdef BRANCH_STATS_EN
    ,
    .branch_count(branch_count),
    .taken_count (taken_count)
`endif
  );

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // 0 = not a branch, 1 = unconditional B, 2 = conditional branch
  function automatic int classify(input logic [15:0] op);
    int v   = int'(op);
    int top = v / 16384;
    int mid = (v / 2048) % 8;
    int sub = (v / 256) % 8;
    if (top == 2 && mid == 4 && sub == 0) return 1;
    if (top == 2 && mid == 7 && sub < 4) return 2;
    return 0;
  endfunction

  function automatic bit cond_taken(input logic [15:0] op, input logic [3:0] fl);
    bit s  = fl[3];
    bit z  = fl[2];
    bit v  = fl[0];
    bit lt = (s != v);
    case ((int'(op) / 256) % 8)
      0: return z;
      1: return lt;
      2: return z || lt;
      3: return !z;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] target_of(input logic [15:0] op);
    int d = int'(op) % 256;
    if (d >= 128) d = d - 256;
    return 16'(d);
  endfunction

  task automatic applyStimulus(input logic iv, input logic [15:0] op, input logic fv,
                               input logic [3:0] fl, input logic ack);
    instr_valid = iv;
    operation   = op;
    flags_valid = fv;
    flags       = fl;
    pc_ack      = ack;
    pcin        = 16'($urandom);
  endtask

  // One instruction from its fetch beat until the block is back in IDLE.
  // w: cycles flags_valid stays low; a: REDIRECT cycles before pc_ack; vpct: flush beat density.
  task automatic run_txn(input string tag, input logic [15:0] op, input int w,
                         input logic [3:0] fl, input int a, input int vpct);
    int          kind  = classify(op);
    bit          tk    = (kind == 2) && cond_taken(op, fl);
    bit          redir = (kind == 1) || tk;
    logic [15:0] tgt   = target_of(op);
    int          wcyc  = (kind == 2) ? w : 0;
    int          beats;
    int          guard;
    logic        iv;

    applyStimulus(1'b1, op, (kind == 2) ? (w == 0) : rbit(),
                  (kind == 2 && w == 0) ? fl : 4'($urandom), rbit());
    @(negedge clock);
    checks++; if (pcsrcout !== 1'b0) $display("[TB] FAIL %s accept pcsrcout: got %b want 0", tag, pcsrcout); else passes++;
    checks++; if (stall !== 1'b0) $display("[TB] FAIL %s accept stall: got %b want 0", tag, stall); else passes++;
    checks++; if (kill !== 1'b0) $display("[TB] FAIL %s accept kill: got %b want 0", tag, kill); else passes++;
    @(posedge clock); #1;
    if (kind != 0) begin
      exp_branches++;
      if (redir) exp_taken++;
    end

    for (int j = 1; j <= wcyc; j++) begin
      applyStimulus(rbit(), 16'($urandom), (j == w), (j == w) ? fl : 4'($urandom), rbit());
      @(negedge clock);
      checks++; if (stall !== 1'b1) $display("[TB] FAIL %s wait stall: got %b want 1", tag, stall); else passes++;
      checks++; if (pcsrcout !== 1'b0) $display("[TB] FAIL %s wait pcsrcout: got %b want 0", tag, pcsrcout); else passes++;
      checks++; if (kill !== 1'b0) $display("[TB] FAIL %s wait kill: got %b want 0", tag, kill); else passes++;
      @(posedge clock); #1;
    end

    if (redir) begin
      for (int k = 0; k <= a; k++) begin
        applyStimulus(rbit(), 16'($urandom), rbit(), 4'($urandom), (k == a));
        @(negedge clock);
        checks++; if (pcsrcout !== 1'b1) $display("[TB] FAIL %s redirect pcsrcout: got %b want 1", tag, pcsrcout); else passes++;
        checks++; if (stall !== 1'b1) $display("[TB] FAIL %s redirect stall: got %b want 1", tag, stall); else passes++;
        checks++; if (pctargetout !== tgt) $display("[TB] FAIL %s redirect pctargetout: got %h want %h", tag, pctargetout, tgt); else passes++;
        checks++; if (kill !== 1'b0) $display("[TB] FAIL %s redirect kill: got %b want 0", tag, kill); else passes++;
        @(posedge clock); #1;
      end
      beats = 0;
      guard = 0;
      while (beats < FD && guard < 40) begin
        iv = ($urandom_range(1, 100) <= vpct);
        applyStimulus(iv, 16'($urandom), rbit(), 4'($urandom), rbit());
        @(negedge clock);
        checks++; if (kill !== iv) $display("[TB] FAIL %s flush kill: got %b want %b", tag, kill, iv); else passes++;
        checks++; if (pcsrcout !== 1'b0) $display("[TB] FAIL %s flush pcsrcout: got %b want 0", tag, pcsrcout); else passes++;
        checks++; if (stall !== 1'b0) $display("[TB] FAIL %s flush stall: got %b want 0", tag, stall); else passes++;
        if (iv) beats++;
        guard++;
        @(posedge clock); #1;
      end
      checks++; if (beats < FD) $display("[TB] FAIL %s flush budget: got %0d beats want %0d", tag, beats, FD); else passes++;
    end
    applyStimulus(1'b0, 16'h0000, 1'b0, 4'h0, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    applyStimulus(1'b1, 16'hA0FE, 1'b1, 4'hF, 1'b1);
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++; if (pcsrcout !== 1'b0) $display("[TB] FAIL reset pcsrcout: got %b want 0", pcsrcout); else passes++;
    checks++; if (pctargetout !== 16'h0000) $display("[TB] FAIL reset pctargetout: got %h want 0000", pctargetout); else passes++;
    checks++; if (stall !== 1'b0) $display("[TB] FAIL reset stall: got %b want 0", stall); else passes++;
    checks++; if (kill !== 1'b0) $display("[TB] FAIL reset kill: got %b want 0", kill); else passes++;
`ifdef BRANCH_STATS_EN
    checks++; if (branch_count !== '0) $display("[TB] FAIL reset branch_count: got %0d want 0", branch_count); else passes++;
    checks++; if (taken_count !== '0) $display("[TB] FAIL reset taken_count: got %0d want 0", taken_count); else passes++;
`endif
    applyStimulus(1'b0, 16'h0000, 1'b0, 4'h0, 1'b0);
    reset = 1'b0;
    exp_branches = 0;
    exp_taken = 0;
    @(posedge clock); #1;
  endtask

  task automatic test_uncond();
    run_txn("b_fe", 16'hA0FE, 0, 4'h0, 1, 100);
    applyStimulus(1'b1, 16'h0000, 1'b0, 4'h0, 1'b0);
    @(negedge clock);
    checks++; if (kill !== 1'b0) $display("[TB] FAIL b_fe post-flush kill: got %b want 0", kill); else passes++;
    @(posedge clock); #1;
  endtask

  task automatic test_wait_flags();
    run_txn("be_wait", 16'hB805, 3, 4'b0100, 0, 100);
  endtask

  task automatic test_not_taken();
    run_txn("bne_nt", 16'hBB10, 0, 4'b0100, 0, 100);
    applyStimulus(1'b1, 16'h1234, 1'b0, 4'h0, 1'b0);
    @(negedge clock);
    checks++; if (pcsrcout !== 1'b0) $display("[TB] FAIL bne_nt pcsrcout: got %b want 0", pcsrcout); else passes++;
    checks++; if (stall !== 1'b0) $display("[TB] FAIL bne_nt stall: got %b want 0", stall); else passes++;
    checks++; if (kill !== 1'b0) $display("[TB] FAIL bne_nt kill: got %b want 0", kill); else passes++;
    @(posedge clock); #1;
  endtask

  task automatic test_cond_mix();
    run_txn("blt_t", 16'hB9F0, 0, 4'b1000, 0, 100);
    run_txn("ble_nt", 16'hBA22, 0, 4'b1001, 0, 100);
    run_txn("nonbr", 16'h8000, 0, 4'h0, 0, 100);
    applyStimulus(1'b0, 16'h0000, 1'b0, 4'h0, 1'b0);
    @(negedge clock);
    checks++; if (pcsrcout !== 1'b0) $display("[TB] FAIL nonbr pcsrcout: got %b want 0", pcsrcout); else passes++;
    checks++; if (stall !== 1'b0) $display("[TB] FAIL nonbr stall: got %b want 0", stall); else passes++;
    @(posedge clock); #1;
  endtask

  task automatic test_reset_mid();
    applyStimulus(1'b1, 16'hA0FE, 1'b0, 4'h0, 1'b0);
    @(posedge clock); #1;
    applyStimulus(1'b0, 16'h0000, 1'b0, 4'h0, 1'b0);
    @(negedge clock);
    checks++; if (pcsrcout !== 1'b1) $display("[TB] FAIL midreset pre pcsrcout: got %b want 1", pcsrcout); else passes++;
    #1 reset = 1'b1;
    #1;
    checks++; if (pcsrcout !== 1'b0) $display("[TB] FAIL midreset pcsrcout: got %b want 0", pcsrcout); else passes++;
    checks++; if (stall !== 1'b0) $display("[TB] FAIL midreset stall: got %b want 0", stall); else passes++;
    checks++; if (pctargetout !== 16'h0000) $display("[TB] FAIL midreset pctargetout: got %h want 0000", pctargetout); else passes++;
    reset = 1'b0;
    exp_branches = 0;
    exp_taken = 0;
    @(posedge clock); #1;
    run_txn("b_after_reset", 16'hA003, 0, 4'h0, 0, 100);
  endtask

  task automatic test_random();
    logic [15:0] op;
    logic [1:0]  cc;
    for (int n = 0; n < 60; n++) begin
      cc = 2'($urandom);
      case ($urandom_range(0, 3))
        0:       op = {8'hA0, 8'($urandom)};
        1, 2:    op = {2'b10, 3'b111, 1'b0, cc, 8'($urandom)};
        default: op = 16'($urandom);
      endcase
      run_txn("random", op, $urandom_range(0, 3), 4'($urandom), $urandom_range(0, 2), 60);
    end
`ifdef BRANCH_STATS_EN
    checks++; if (int'(branch_count) != exp_branches) $display("[TB] FAIL random branch_count: got %0d want %0d", branch_count, exp_branches); else passes++;
    checks++; if (int'(taken_count) != exp_taken) $display("[TB] FAIL random taken_count: got %0d want %0d", taken_count, exp_taken); else passes++;
`endif
  endtask

`ifdef BRANCH_STATS_EN
  task automatic test_stats();
    #1 reset = 1'b1;
    #1 reset = 1'b0;
    @(posedge clock); #1;
    run_txn("st_b", 16'hA010, 0, 4'h0, 0, 100);
    run_txn("st_be_t", 16'hB801, 1, 4'b0100, 0, 100);
    run_txn("st_bne_t", 16'hBB02, 0, 4'b0000, 1, 100);
    run_txn("st_blt_nt", 16'hB903, 2, 4'b0000, 0, 100);
    run_txn("st_be_nt", 16'hB804, 0, 4'b0000, 0, 100);
    checks++; if (branch_count !== 16'd5) $display("[TB] FAIL stats branch_count: got %0d want 5", branch_count); else passes++;
    checks++; if (taken_count !== 16'd3) $display("[TB] FAIL stats taken_count: got %0d want 3", taken_count); else passes++;
  endtask
`endif

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_uncond();
    test_wait_flags();
    test_not_taken();
    test_cond_mix();
    test_reset_mid();
    test_random();
`ifdef BRANCH_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
